// File: rtl/register_file_one_hot_write.sv
// ---------------------------------------------------------------------------
// register_file_one_hot_write
//
// Thirty-two-entry general-purpose register file for the writeback stage.
// Write strobes come straight from the 32-way one-hot write-enable demux.
// Register 0 is hardwired to zero and has no storage.
//
// Ports
//   CLK           rising-edge clock
//   RESET_N       asynchronous active-low reset (clears registers, DIRTY,
//                 ONEHOT_ERROR)
//   WRITE_EN      one-hot write strobes; bit i writes register i;
//                 all-zero means no write
//   WRITE_DATA    data written to the strobed register
//   READ_ADDR_A/B read port register indices
//   READ_DATA_A/B combinational read data with write-first bypass
//   CLEAR_ERROR   synchronous clear of ONEHOT_ERROR (a set wins)
//   ONEHOT_ERROR  sticky flag, raised by a multi-hot WRITE_EN
//   DIRTY         bit i set once register i has been written; bit 0 is 0
// ---------------------------------------------------------------------------
module register_file_one_hot_write #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [31:0]           WRITE_EN,
    input  logic [DATA_WIDTH-1:0] WRITE_DATA,
    input  logic [4:0]            READ_ADDR_A,
    input  logic [4:0]            READ_ADDR_B,
    output logic [DATA_WIDTH-1:0] READ_DATA_A,
    output logic [DATA_WIDTH-1:0] READ_DATA_B,
    input  logic                  CLEAR_ERROR,
    output logic                  ONEHOT_ERROR,
    output logic [31:0]           DIRTY
);

    typedef enum logic [1:0] {
        STROBE_IDLE    = 2'd0,
        STROBE_LEGAL   = 2'd1,
        STROBE_ILLEGAL = 2'd2
    } strobe_class_t;

    // True when more than one bit is set: clearing the lowest set bit
    // leaves something behind only for a multi-hot vector.
    function automatic logic is_multi_hot(input logic [31:0] vec);
        return ((vec & (vec - 32'd1)) != 32'd0);
    endfunction

    // Encode a one-hot vector to its bit index. Only meaningful when the
    // vector really is one-hot; OR-ing keeps it a small, flat encoder.
    function automatic logic [4:0] onehot_index(input logic [31:0] vec);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (vec[i]) begin
                idx = idx | 5'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    strobe_class_t         strobe_class_s;
    logic [4:0]            write_idx_s;
    logic [31:1]           commit_s;
    logic [DATA_WIDTH-1:0] read_a_s;
    logic [DATA_WIDTH-1:0] read_b_s;

    logic [DATA_WIDTH-1:0] reg_r [1:31];
    logic [31:1]           dirty_r;
    logic                  error_r;

    // Classify this cycle's strobe vector and derive the per-register commits.
    always_comb begin
        write_idx_s = onehot_index(WRITE_EN);
        if (WRITE_EN == 32'd0) begin
            strobe_class_s = STROBE_IDLE;
        end else if (is_multi_hot(WRITE_EN)) begin
            strobe_class_s = STROBE_ILLEGAL;
        end else begin
            strobe_class_s = STROBE_LEGAL;
        end
        // Bit 0 is dropped: a strobe on register 0 is legal but writes nothing.
        case (strobe_class_s)
            STROBE_LEGAL: commit_s = WRITE_EN[31:1];
            default:      commit_s = 31'd0;
        endcase
    end

    // Register storage; a multi-hot strobe commits nothing at all.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 1; i < 32; i++) begin
                reg_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (commit_s[i]) begin
                    reg_r[i] <= WRITE_DATA;
                end else begin
                    reg_r[i] <= reg_r[i];
                end
            end
        end
    end

    // Written-since-reset mask; accumulates every committed write.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            dirty_r <= 31'd0;
        end else begin
            dirty_r <= dirty_r | commit_s;
        end
    end

    // Sticky multi-hot error flag; a new error beats a simultaneous clear.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            error_r <= 1'b0;
        end else if (strobe_class_s == STROBE_ILLEGAL) begin
            error_r <= 1'b1;
        end else if (CLEAR_ERROR) begin
            error_r <= 1'b0;
        end else begin
            error_r <= error_r;
        end
    end

    // Read port A: storage lookup, then write-first bypass, index 0 reads 0.
    always_comb begin
        read_a_s = {DATA_WIDTH{1'b0}};
        for (int i = 1; i < 32; i++) begin
            if (READ_ADDR_A == 5'(i)) begin
                read_a_s = reg_r[i];
            end else begin
                read_a_s = read_a_s;
            end
        end
        if ((strobe_class_s == STROBE_LEGAL) && (write_idx_s == READ_ADDR_A)
                && (READ_ADDR_A != 5'd0)) begin
            read_a_s = WRITE_DATA;
        end else begin
            read_a_s = read_a_s;
        end
    end

    // Read port B: identical to port A and fully independent of it.
    always_comb begin
        read_b_s = {DATA_WIDTH{1'b0}};
        for (int i = 1; i < 32; i++) begin
            if (READ_ADDR_B == 5'(i)) begin
                read_b_s = reg_r[i];
            end else begin
                read_b_s = read_b_s;
            end
        end
        if ((strobe_class_s == STROBE_LEGAL) && (write_idx_s == READ_ADDR_B)
                && (READ_ADDR_B != 5'd0)) begin
            read_b_s = WRITE_DATA;
        end else begin
            read_b_s = read_b_s;
        end
    end

    assign READ_DATA_A  = read_a_s;
    assign READ_DATA_B  = read_b_s;
    assign ONEHOT_ERROR = error_r;
    assign DIRTY        = {dirty_r, 1'b0};

endmodule

// File: tb/tb_register_file_one_hot_write.sv
// Directed bench for register_file_one_hot_write: reset state, bypass,
// register-0 writes, multi-hot rejection and error flag, full sweep,
// back-to-back writes and mid-sequence reset.
module tb_register_file_one_hot_write;

    logic        CLK;
    logic        RESET_N;
    logic [31:0] WRITE_EN;
    logic [31:0] WRITE_DATA;
    logic [4:0]  READ_ADDR_A;
    logic [4:0]  READ_ADDR_B;
    logic [31:0] READ_DATA_A;
    logic [31:0] READ_DATA_B;
    logic        CLEAR_ERROR;
    logic        ONEHOT_ERROR;
    logic [31:0] DIRTY;

    int n_vec;
    int n_err;

    register_file_one_hot_write #(.DATA_WIDTH(32)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .WRITE_EN     (WRITE_EN),
        .WRITE_DATA   (WRITE_DATA),
        .READ_ADDR_A  (READ_ADDR_A),
        .READ_ADDR_B  (READ_ADDR_B),
        .READ_DATA_A  (READ_DATA_A),
        .READ_DATA_B  (READ_DATA_B),
        .CLEAR_ERROR  (CLEAR_ERROR),
        .ONEHOT_ERROR (ONEHOT_ERROR),
        .DIRTY        (DIRTY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        RESET_N     = 1'b0;
        WRITE_EN    = 32'd0;
        WRITE_DATA  = 32'd0;
        READ_ADDR_A = 5'd0;
        READ_ADDR_B = 5'd0;
        CLEAR_ERROR = 1'b0;
        #12;
        READ_ADDR_A = 5'd4;
        #1;
        check("in_reset_rd_a", {31'd0, 1'b0} | READ_DATA_A, 32'd0);
        RESET_N = 1'b1;
        #1;

        // Reset state on all indices, both ports in opposite order
        for (int i = 0; i < 32; i++) begin
            READ_ADDR_A = 5'(i);
            READ_ADDR_B = 5'(31 - i);
            #1;
            check("reset_rd_a", READ_DATA_A, 32'd0);
            check("reset_rd_b", READ_DATA_B, 32'd0);
        end
        check("reset_dirty", DIRTY, 32'd0);
        check("reset_err", {31'd0, ONEHOT_ERROR}, 32'd0);

        // Bypass of a write to register 5, then stored value
        tick();
        WRITE_EN    = 32'h0000_0020;
        WRITE_DATA  = 32'hDEAD_BEEF;
        READ_ADDR_A = 5'd5;
        READ_ADDR_B = 5'd6;
        #1;
        check("bypass_a", READ_DATA_A, 32'hDEAD_BEEF);
        check("no_bypass_b", READ_DATA_B, 32'd0);
        check("dirty_before_edge", DIRTY, 32'd0);
        tick();
        WRITE_EN = 32'd0;
        #1;
        check("stored_a", READ_DATA_A, 32'hDEAD_BEEF);
        check("dirty_r5", DIRTY, 32'h0000_0020);

        // Write to register 0 does nothing and is not an error
        WRITE_EN    = 32'h0000_0001;
        WRITE_DATA  = 32'h0000_1234;
        READ_ADDR_A = 5'd0;
        #1;
        check("r0_bypass", READ_DATA_A, 32'd0);
        tick();
        WRITE_EN = 32'd0;
        #1;
        check("r0_read", READ_DATA_A, 32'd0);
        check("r0_dirty", DIRTY, 32'h0000_0020);
        check("r0_err", {31'd0, ONEHOT_ERROR}, 32'd0);

        // Preload registers 8 and 9, then a multi-hot write to both
        WRITE_EN   = 32'h0000_0100;
        WRITE_DATA = 32'h0000_0011;
        tick();
        WRITE_EN   = 32'h0000_0200;
        WRITE_DATA = 32'h0000_0022;
        tick();
        WRITE_EN    = 32'h0000_0300;
        WRITE_DATA  = 32'hFFFF_FFFF;
        READ_ADDR_A = 5'd8;
        READ_ADDR_B = 5'd9;
        #1;
        check("multi_no_bypass_a", READ_DATA_A, 32'h0000_0011);
        check("multi_no_bypass_b", READ_DATA_B, 32'h0000_0022);
        check("multi_err_same_cycle", {31'd0, ONEHOT_ERROR}, 32'd0);
        tick();
        WRITE_EN = 32'd0;
        #1;
        check("multi_keep_a", READ_DATA_A, 32'h0000_0011);
        check("multi_keep_b", READ_DATA_B, 32'h0000_0022);
        check("multi_err_set", {31'd0, ONEHOT_ERROR}, 32'd1);
        check("multi_dirty", DIRTY, 32'h0000_0320);

        // Clear together with another multi-hot: set wins, no write to r1
        CLEAR_ERROR = 1'b1;
        WRITE_EN    = 32'h0000_0003;
        WRITE_DATA  = 32'h5555_5555;
        READ_ADDR_A = 5'd1;
        #1;
        check("multi_r1_no_bypass", READ_DATA_A, 32'd0);
        tick();
        CLEAR_ERROR = 1'b0;
        WRITE_EN    = 32'd0;
        #1;
        check("clear_vs_set", {31'd0, ONEHOT_ERROR}, 32'd1);
        check("multi_r1_read", READ_DATA_A, 32'd0);
        check("multi_dirty2", DIRTY, 32'h0000_0320);
        CLEAR_ERROR = 1'b1;
        tick();
        CLEAR_ERROR = 1'b0;
        #1;
        check("clear_alone", {31'd0, ONEHOT_ERROR}, 32'd0);

        // Both ports bypass the same index in the same cycle
        WRITE_EN    = 32'h0000_0080;
        WRITE_DATA  = 32'hA5A5_A5A5;
        READ_ADDR_A = 5'd7;
        READ_ADDR_B = 5'd7;
        #1;
        check("dual_bypass_a", READ_DATA_A, 32'hA5A5_A5A5);
        check("dual_bypass_b", READ_DATA_B, 32'hA5A5_A5A5);
        tick();

        // Sustained writes to every index 1..31
        for (int i = 1; i < 32; i++) begin
            WRITE_EN   = 32'd1 << i;
            WRITE_DATA = 32'(i) * 32'h0101_0101;
            tick();
        end
        WRITE_EN = 32'd0;
        for (int i = 1; i < 32; i++) begin
            READ_ADDR_A = 5'(i);
            READ_ADDR_B = 5'(32 - i);
            #1;
            check("sweep_a", READ_DATA_A, 32'(i) * 32'h0101_0101);
            check("sweep_b", READ_DATA_B, 32'(32 - i) * 32'h0101_0101);
        end
        check("sweep_dirty", DIRTY, 32'hFFFF_FFFE);
        check("sweep_err", {31'd0, ONEHOT_ERROR}, 32'd0);

        // Back-to-back writes to register 3: last edge wins
        tick();
        WRITE_EN   = 32'h0000_0008;
        WRITE_DATA = 32'h0000_AAAA;
        tick();
        WRITE_DATA = 32'h0000_BBBB;
        tick();
        WRITE_EN    = 32'd0;
        READ_ADDR_A = 5'd3;
        #1;
        check("b2b_last_wins", READ_DATA_A, 32'h0000_BBBB);

        // Reset asserted mid-sequence with a pending write to register 2
        WRITE_EN    = 32'h0000_0004;
        WRITE_DATA  = 32'h0000_CAFE;
        READ_ADDR_A = 5'd3;
        READ_ADDR_B = 5'd31;
        #1;
        RESET_N = 1'b0;
        #1;
        check("async_rst_a", READ_DATA_A, 32'd0);
        check("async_rst_b", READ_DATA_B, 32'd0);
        check("async_rst_dirty", DIRTY, 32'd0);
        tick();
        WRITE_EN = 32'd0;
        #2;
        RESET_N = 1'b1;
        READ_ADDR_A = 5'd2;
        READ_ADDR_B = 5'd2;
        #1;
        check("rst_lost_write_a", READ_DATA_A, 32'd0);
        check("rst_lost_write_b", READ_DATA_B, 32'd0);
        check("rst_dirty", DIRTY, 32'd0);
        check("rst_err", {31'd0, ONEHOT_ERROR}, 32'd0);

        // First write immediately after release
        WRITE_EN   = 32'h0000_0004;
        WRITE_DATA = 32'h0BAD_F00D;
        tick();
        WRITE_EN = 32'd0;
        #1;
        check("post_rst_write", READ_DATA_A, 32'h0BAD_F00D);
        check("post_rst_dirty", DIRTY, 32'h0000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
